// File: rtl/uart_frame_pkg.sv
// -----------------------------------------------------------------------------
// uart_frame_pkg
//   Shared definitions for the UART framing layer (RX frame controller and the
//   matching TX framer).
//   - frame_state_e     : parser state encoding (3 bits)
//   - DEFAULT_SYNC_BYTE : frame start marker
//   - chk_update()      : running XOR checksum step. It covers ADDR, LEN and
//                         the payload bytes. SYNC is excluded.
// -----------------------------------------------------------------------------
package uart_frame_pkg;

  typedef enum logic [2:0] {
    HUNT    = 3'd0,
    ADDR    = 3'd1,
    LEN     = 3'd2,
    PAYLOAD = 3'd3,
    CHK     = 3'd4,
    DRAIN   = 3'd5
  } frame_state_e;

  localparam logic [7:0] DEFAULT_SYNC_BYTE = 8'hA5;

  // One checksum step. The RX and TX sides must fold bytes identically.
  function automatic logic [7:0] chk_update(input logic [7:0] chk,
                                            input logic [7:0] data);
    return chk ^ data;
  endfunction

endpackage

// File: rtl/uart_frame_buf.sv
// -----------------------------------------------------------------------------
// uart_frame_buf
//   Payload buffer: a DEPTH x 8 register array with one synchronous write port
//   and one combinational read port.
//   Ports:
//     i_Clock    in   1   clock
//     i_Wr_En    in   1   write strobe
//     i_Wr_Idx   in   AW  write index
//     i_Wr_Data  in   8   write data
//     i_Rd_Idx   in   AW  read index
//     o_Rd_Data  out  8   read data (combinational)
// -----------------------------------------------------------------------------
module uart_frame_buf #(
  parameter int DEPTH = 16,
  parameter int AW    = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
  input  logic          i_Clock,
  input  logic          i_Wr_En,
  input  logic [AW-1:0] i_Wr_Idx,
  input  logic [7:0]    i_Wr_Data,
  input  logic [AW-1:0] i_Rd_Idx,
  output logic [7:0]    o_Rd_Data
);

  logic [7:0] mem [DEPTH];

  // NOTE: the array has no reset. Every entry is written before it is read
  // within a frame. Clearing the array would only add reset fan-out to plain
  // data flops.
  always_ff @(posedge i_Clock) begin
    if (i_Wr_En) begin
      mem[i_Wr_Idx] <= i_Wr_Data;
    end
  end

  assign o_Rd_Data = mem[i_Rd_Idx];

endmodule

// File: rtl/uart_rx_frame_ctrl.sv
// -----------------------------------------------------------------------------
// uart_rx_frame_ctrl
//   Frame controller behind the UART receiver. It parses the frame
//   SYNC, ADDR, LEN, LEN payload bytes, CHK. It buffers the payload and checks
//   the XOR checksum, then streams good frames out over valid/ready. Bad frames
//   and timed-out frames are dropped, and each error raises a one-cycle pulse.
//   Ports:
//     i_Clock        in   1  clock
//     i_Reset        in   1  synchronous reset, active-high
//     i_RX_DV        in   1  byte strobe from the receiver, 1 cycle wide
//     i_RX_Byte      in   8  received byte, valid while i_RX_DV=1
//     o_Out_Valid    out  1  payload byte available
//     i_Out_Ready    in   1  sink accepts the byte
//     o_Out_Byte     out  8  payload byte
//     o_Out_Last     out  1  final payload byte of the frame
//     o_Out_Addr     out  8  ADDR of the last good frame (held until the next one)
//     o_Busy         out  1  parser is not in HUNT
//     o_Err_Chk      out  1  pulse: checksum mismatch
//     o_Err_Len      out  1  pulse: LEN==0 or LEN>MAX_LEN
//     o_Err_Timeout  out  1  pulse: inter-byte gap expired mid-frame
//     o_Drop         out  1  pulse: byte arrived during DRAIN and was discarded
// -----------------------------------------------------------------------------
module uart_rx_frame_ctrl
  import uart_frame_pkg::*;
#(
  parameter int         CLKS_PER_BIT = 104,
  parameter int         MAX_LEN      = 16,
  parameter logic [7:0] SYNC_BYTE    = DEFAULT_SYNC_BYTE,
  parameter int         TIMEOUT_CLKS = 20 * CLKS_PER_BIT
) (
  input  logic       i_Clock,
  input  logic       i_Reset,
  input  logic       i_RX_DV,
  input  logic [7:0] i_RX_Byte,
  output logic       o_Out_Valid,
  input  logic       i_Out_Ready,
  output logic [7:0] o_Out_Byte,
  output logic       o_Out_Last,
  output logic [7:0] o_Out_Addr,
  output logic       o_Busy,
  output logic       o_Err_Chk,
  output logic       o_Err_Len,
  output logic       o_Err_Timeout,
  output logic       o_Drop
);

  localparam int IDX_W  = $clog2(MAX_LEN + 1);
  localparam int GAP_W  = $clog2(TIMEOUT_CLKS);
  localparam int BUF_AW = (MAX_LEN > 1) ? $clog2(MAX_LEN) : 1;

  localparam logic [GAP_W-1:0] GAP_LAST  = GAP_W'(TIMEOUT_CLKS - 1);
  localparam logic [7:0]       MAX_LEN_B = 8'(MAX_LEN);

  frame_state_e     state;
  logic [7:0]       frame_addr;  // ADDR of the frame being parsed
  logic [IDX_W-1:0] len_q;
  logic [IDX_W-1:0] idx_q;       // payload write index while parsing, read index in DRAIN
  logic [7:0]       chk_q;
  logic [GAP_W-1:0] gap_q;

  logic       parsing;
  logic       last_idx;
  logic       buf_wr_en;
  logic [7:0] buf_rd_data;

  assign parsing  = state inside {ADDR, LEN, PAYLOAD, CHK};
  assign last_idx = (idx_q == len_q - 1'b1);

  assign buf_wr_en = i_RX_DV && (state == PAYLOAD) && !i_Reset;

  uart_frame_buf #(
    .DEPTH (MAX_LEN),
    .AW    (BUF_AW)
  ) u_buf (
    .i_Clock   (i_Clock),
    .i_Wr_En   (buf_wr_en),
    .i_Wr_Idx  (idx_q[BUF_AW-1:0]),
    .i_Wr_Data (i_RX_Byte),
    .i_Rd_Idx  (idx_q[BUF_AW-1:0]),
    .o_Rd_Data (buf_rd_data)
  );

  // Stream outputs decode directly from registered state. Data is gated so
  // every output reads 0 outside DRAIN, including right after reset. idx_q
  // only advances on a handshake, so the byte holds while the sink stalls.
  assign o_Out_Valid = (state == DRAIN);
  assign o_Out_Byte  = o_Out_Valid ? buf_rd_data : 8'h00;
  assign o_Out_Last  = o_Out_Valid && last_idx;
  assign o_Busy      = (state != HUNT);

  // NOTE: every register in this block uses non-blocking assignment. The
  // pulse defaults at the top can then be overridden by later assignments in
  // the same edge, and all reads see the pre-edge values.
  always_ff @(posedge i_Clock) begin
    o_Err_Chk     <= 1'b0;
    o_Err_Len     <= 1'b0;
    o_Err_Timeout <= 1'b0;
    o_Drop        <= 1'b0;

    if (i_Reset) begin
      state      <= HUNT;
      frame_addr <= '0;
      o_Out_Addr <= '0;
      len_q      <= '0;
      idx_q      <= '0;
      chk_q      <= '0;
      gap_q      <= '0;
    end else begin
      // The gap counter restarts on every byte and only runs mid-frame.
      if (i_RX_DV) begin
        gap_q <= '0;
      end else if (parsing) begin
        gap_q <= gap_q + 1'b1;
      end

      case (state)
        HUNT: begin
          if (i_RX_DV && (i_RX_Byte == SYNC_BYTE)) begin
            state <= ADDR;
          end
        end

        ADDR, LEN, PAYLOAD, CHK: begin
          // A byte in the expiry cycle takes priority over the timeout.
          if (i_RX_DV) begin
            unique case (state)
              ADDR: begin
                frame_addr <= i_RX_Byte;
                chk_q      <= i_RX_Byte;
                state      <= LEN;
              end
              LEN: begin
                if ((i_RX_Byte == 8'h00) || (i_RX_Byte > MAX_LEN_B)) begin
                  state     <= HUNT;
                  o_Err_Len <= 1'b1;
                end else begin
                  len_q <= i_RX_Byte[IDX_W-1:0];
                  chk_q <= chk_update(chk_q, i_RX_Byte);
                  idx_q <= '0;
                  state <= PAYLOAD;
                end
              end
              PAYLOAD: begin
                chk_q <= chk_update(chk_q, i_RX_Byte);
                idx_q <= idx_q + 1'b1;
                if (last_idx) begin
                  state <= CHK;
                end
              end
              CHK: begin
                if (i_RX_Byte == chk_q) begin
                  state      <= DRAIN;
                  idx_q      <= '0;
                  o_Out_Addr <= frame_addr;
                end else begin
                  state     <= HUNT;
                  o_Err_Chk <= 1'b1;
                end
              end
              default: ;
            endcase
          end else if (gap_q == GAP_LAST) begin
            state         <= HUNT;
            o_Err_Timeout <= 1'b1;
            gap_q         <= '0;
          end
        end

        DRAIN: begin
          // The receiver cannot be stalled, so bytes arriving while the
          // buffer drains are discarded and flagged.
          if (i_RX_DV) begin
            o_Drop <= 1'b1;
          end
          if (i_Out_Ready) begin
            if (last_idx) begin
              state <= HUNT;
              idx_q <= '0;
            end else begin
              idx_q <= idx_q + 1'b1;
            end
          end
        end

        default: state <= HUNT;
      endcase
    end
  end

endmodule
